compmult_acc: RTL

COMPMULT_ACC -- requirements
Module: compmult_acc

---
 rtl/compmult_pkg.sv | 53 +++++
 rtl/compmult_core.sv | 115 +++++++++++
 rtl/compmult_acc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/compmult_pkg.sv
// -----------------------------------------------------------------------------
// compmult_pkg
// Shared definitions for the complex multiply-accumulate block:
//   - p_dw()   : full-precision complex product width (A_DW + B_DW + 1)
//   - acc_dw() : accumulator width (p_dw + clog2(acc_len))
//   - LATENCY  : cycles from the capture edge of a block's final sample to ov
//   - signed complex typedefs at the default component widths
// Configuration macro: COMPMULT_ACC_ROUND_EN (round half-up + saturate,
// one extra output register stage).
// -----------------------------------------------------------------------------
package compmult_pkg;

   localparam int A_DW_DEF = 25;
   localparam int B_DW_DEF = 18;

   localparam int LATENCY_TRUNC = 4;
   localparam int LATENCY_ROUND = 5;

`ifdef COMPMULT_ACC_ROUND_EN
   localparam int LATENCY = LATENCY_ROUND;
`else
   localparam int LATENCY = LATENCY_TRUNC;
`endif

   // Width of a complex product component: the cross-term sum of two
   // A_DW x B_DW products needs one bit beyond a single product.
   function automatic int p_dw(input int a_dw, input int b_dw);
      return a_dw + b_dw + 1;
   endfunction

   // Accumulator width: enough headroom for acc_len full-scale products.
   function automatic int acc_dw(input int a_dw, input int b_dw, input int acc_len);
      return p_dw(a_dw, b_dw) + $clog2(acc_len);
   endfunction

   localparam int P_DW_DEF = A_DW_DEF + B_DW_DEF + 1;

   typedef struct packed {
      logic signed [A_DW_DEF-1:0] re;
      logic signed [A_DW_DEF-1:0] im;
   } cplx_a_t;

   typedef struct packed {
      logic signed [B_DW_DEF-1:0] re;
      logic signed [B_DW_DEF-1:0] im;
   } cplx_b_t;

   typedef struct packed {
      logic signed [P_DW_DEF-1:0] re;
      logic signed [P_DW_DEF-1:0] im;
   } cplx_p_t;

endpackage

// File: rtl/compmult_core.sv
// -----------------------------------------------------------------------------
// compmult_core
// Three-stage pipelined complex multiplier (input reg, product reg, sum reg).
// Valid and conjugate flags travel alongside the data; iclr kills every valid
// in flight and drops the sample presented with it.
// Configuration macro: COMPMULT_ACC_ROUND_EN (not used in this file).
// Ports:
//   iclk, iresetn     clock, async active-low reset
//   iclr              synchronous flush of pipeline valids
//   iv, iconj         sample valid, multiply by conj(B)
//   ia_i, ia_q        A components (A_DW, signed)
//   ib_i, ib_q        B components (B_DW, signed)
//   sum_v             product valid leaving the pipeline
//   sum_i, sum_q      complex product (P_DW, signed)
// -----------------------------------------------------------------------------
module compmult_core
   import compmult_pkg::*;
#(
   parameter  int A_DW = 25,
   parameter  int B_DW = 18,
   localparam int P_DW = p_dw(A_DW, B_DW)
) (
   input  logic                   iclk,
   input  logic                   iresetn,
   input  logic                   iclr,
   input  logic                   iv,
   input  logic                   iconj,
   input  logic signed [A_DW-1:0] ia_i,
   input  logic signed [A_DW-1:0] ia_q,
   input  logic signed [B_DW-1:0] ib_i,
   input  logic signed [B_DW-1:0] ib_q,
   output logic                   sum_v,
   output logic signed [P_DW-1:0] sum_i,
   output logic signed [P_DW-1:0] sum_q
);

   localparam int M_DW = A_DW + B_DW;

   logic                   v1, conj1;
   logic signed [A_DW-1:0] a1_i, a1_q;
   logic signed [B_DW-1:0] b1_i, b1_q;

   logic                   v2, conj2;
   logic signed [M_DW-1:0] p_ii, p_qq, p_iq, p_qi;

   logic                   take;

   assign take = iv & ~iclr;

   // Stage 1: input register. Data only loads on an accepted sample.
   // NOTE: sequential state uses non-blocking assignment so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         v1    <= 1'b0;
         conj1 <= 1'b0;
         a1_i  <= '0;
         a1_q  <= '0;
         b1_i  <= '0;
         b1_q  <= '0;
      end else begin
         v1 <= take;
         if (take) begin
            conj1 <= iconj;
            a1_i  <= ia_i;
            a1_q  <= ia_q;
            b1_i  <= ib_i;
            b1_q  <= ib_q;
         end
      end
   end

   // Stage 2: the four partial products at full A_DW+B_DW precision.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         v2    <= 1'b0;
         conj2 <= 1'b0;
         p_ii  <= '0;
         p_qq  <= '0;
         p_iq  <= '0;
         p_qi  <= '0;
      end else begin
         v2 <= v1 & ~iclr;
         if (v1) begin
            conj2 <= conj1;
            p_ii  <= M_DW'(a1_i) * M_DW'(b1_i);
            p_qq  <= M_DW'(a1_q) * M_DW'(b1_q);
            p_iq  <= M_DW'(a1_i) * M_DW'(b1_q);
            p_qi  <= M_DW'(a1_q) * M_DW'(b1_i);
         end
      end
   end

   // Stage 3: combine cross terms. Conjugating B flips the sign of bq, which
   // swaps the add/subtract on both components.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         sum_v <= 1'b0;
         sum_i <= '0;
         sum_q <= '0;
      end else begin
         sum_v <= v2 & ~iclr;
         if (v2) begin
            if (conj2) begin
               sum_i <= P_DW'(p_ii) + P_DW'(p_qq);
               sum_q <= P_DW'(p_qi) - P_DW'(p_iq);
            end else begin
               sum_i <= P_DW'(p_ii) - P_DW'(p_qq);
               sum_q <= P_DW'(p_iq) + P_DW'(p_qi);
            end
         end
      end
   end

endmodule

// File: rtl/compmult_acc.sv
// -----------------------------------------------------------------------------
// compmult_acc
// Pipelined complex multiplier followed by a block accumulator that sums
// ACC_LEN valid products and presents the result with a one-cycle ov pulse.
// Configuration macro: COMPMULT_ACC_ROUND_EN
//   undefined : output is the top OUT_DW accumulator bits (floor), latency 4
//   defined   : round half-up and saturate to OUT_DW, latency 5
// Ports:
//   iclk, iresetn     clock, async active-low reset
//   iclr              synchronous flush of accumulator, counter and pipeline
//   iv, iconj         sample valid, multiply by conj(B)
//   ia_i, ia_q        A components (A_DW, signed)
//   ib_i, ib_q        B components (B_DW, signed)
//   ov                one-cycle result valid pulse
//   oc_i, oc_q        accumulated result (OUT_DW, signed), held between pulses
// -----------------------------------------------------------------------------
module compmult_acc
   import compmult_pkg::*;
#(
   parameter int A_DW    = 25,
   parameter int B_DW    = 18,
   parameter int ACC_LEN = 4,
   parameter int OUT_DW  = A_DW + B_DW + 1 + $clog2(ACC_LEN)
) (
   input  logic                     iclk,
   input  logic                     iresetn,
   input  logic                     iclr,
   input  logic                     iv,
   input  logic                     iconj,
   input  logic signed [A_DW-1:0]   ia_i,
   input  logic signed [A_DW-1:0]   ia_q,
   input  logic signed [B_DW-1:0]   ib_i,
   input  logic signed [B_DW-1:0]   ib_q,
   output logic                     ov,
   output logic signed [OUT_DW-1:0] oc_i,
   output logic signed [OUT_DW-1:0] oc_q
);

   localparam int P_DW   = p_dw(A_DW, B_DW);
   localparam int ACC_DW = acc_dw(A_DW, B_DW, ACC_LEN);
   localparam int CNT_DW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_DW-1:0] LAST_CNT = CNT_DW'(ACC_LEN - 1);

   logic                   sum_v;
   logic signed [P_DW-1:0] sum_i, sum_q;

   logic [CNT_DW-1:0]        cnt;
   logic signed [ACC_DW-1:0] acc_i, acc_q;
   logic                     last_q;
   logic                     is_first, is_last;

   compmult_core #(
      .A_DW (A_DW),
      .B_DW (B_DW)
   ) u_core (
      .iclk    (iclk),
      .iresetn (iresetn),
      .iclr    (iclr),
      .iv      (iv),
      .iconj   (iconj),
      .ia_i    (ia_i),
      .ia_q    (ia_q),
      .ib_i    (ib_i),
      .ib_q    (ib_q),
      .sum_v   (sum_v),
      .sum_i   (sum_i),
      .sum_q   (sum_q)
   );

   assign is_first = (cnt == '0);
   assign is_last  = (cnt == LAST_CNT);

   // Accumulator and block counter only move on a valid product, so input
   // gaps simply stall the block. The first product of a block loads rather
   // than adds, which lets the next block start while the previous result
   // is still being registered out.
   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         cnt    <= '0;
         acc_i  <= '0;
         acc_q  <= '0;
         last_q <= 1'b0;
      end else if (iclr) begin
         cnt    <= '0;
         acc_i  <= '0;
         acc_q  <= '0;
         last_q <= 1'b0;
      end else begin
         last_q <= sum_v & is_last;
         if (sum_v) begin
            cnt   <= is_last ? '0 : cnt + CNT_DW'(1);
            acc_i <= is_first ? ACC_DW'(sum_i) : acc_i + ACC_DW'(sum_i);
            acc_q <= is_first ? ACC_DW'(sum_q) : acc_q + ACC_DW'(sum_q);
         end
      end
   end

`ifdef COMPMULT_ACC_ROUND_EN

   localparam int SH = ACC_DW - OUT_DW;
   // Half an output LSB; zero when no bits are discarded.
   localparam logic signed [ACC_DW:0] HALF =
      (SH > 0) ? ((ACC_DW + 1)'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;

   logic                   rnd_v;
   logic signed [ACC_DW:0] rnd_i, rnd_q;

   // Keep the rounded value one bit wider than the accumulator so that the
   // +HALF can never wrap; saturation then only has to look at the top two
   // bits of the retained slice.
   function automatic logic signed [OUT_DW-1:0] sat_slice(input logic signed [ACC_DW:0] r);
      logic [OUT_DW:0] w;
      w = r[ACC_DW -: OUT_DW + 1];
      if (w[OUT_DW] != w[OUT_DW-1])
         sat_slice = w[OUT_DW] ? {1'b1, {(OUT_DW - 1){1'b0}}}
                               : {1'b0, {(OUT_DW - 1){1'b1}}};
      else
         sat_slice = w[OUT_DW-1:0];
   endfunction

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         rnd_v <= 1'b0;
         rnd_i <= '0;
         rnd_q <= '0;
      end else begin
         rnd_v <= last_q;
         if (last_q) begin
            rnd_i <= (ACC_DW + 1)'(acc_i) + HALF;
            rnd_q <= (ACC_DW + 1)'(acc_q) + HALF;
         end
      end
   end

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         ov   <= 1'b0;
         oc_i <= '0;
         oc_q <= '0;
      end else begin
         ov <= rnd_v;
         if (rnd_v) begin
            oc_i <= sat_slice(rnd_i);
            oc_q <= sat_slice(rnd_q);
         end
      end
   end

`else

   // Low accumulator bits are dropped by the floor truncation.
   logic unused_acc_bits;
   assign unused_acc_bits = ^{acc_i, acc_q};

   always_ff @(posedge iclk or negedge iresetn) begin
      if (!iresetn) begin
         ov   <= 1'b0;
         oc_i <= '0;
         oc_q <= '0;
      end else begin
         ov <= last_q;
         if (last_q) begin
            oc_i <= acc_i[ACC_DW-1 -: OUT_DW];
            oc_q <= acc_q[ACC_DW-1 -: OUT_DW];
         end
      end
   end

`endif

endmodule
